cam_sensor_emu: RTL and testbench

Parallel camera-sensor emulator that drives the 8-bit DVP-style pixel bus (`Pclk`, `Href`, `Vsyn`, `data`) that the camera capture path samples. It generates complete frames with programmable geometry and a selectable test pattern, so capture, FIFO and Wishbone readout can be exercised on the FPGA and in simulation without a physical sensor. It sits in `wb_cam` in place of the sensor pins, runs from the system clock, and honours the capture block's `PWDN` output.

---
 rtl/cam_sensor_emu_if.sv | 11 +
 rtl/cam_sensor_emu.sv | 174 +++++++++++++++++
 tb/tb_cam_sensor_emu.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_sensor_emu_if.sv
// DVP-style parallel pixel bus between the sensor emulator and the capture path.
// The master drives Pclk/Href/Vsyn/data; the capture side samples them on Pclk rising.
interface cam_sensor_emu_if;
  logic       Pclk;
  logic       Href;
  logic       Vsyn;
  logic [7:0] data;

  modport master (output Pclk, output Href, output Vsyn, output data);
  modport slave  (input  Pclk, input  Href, input  Vsyn, input  data);
endinterface

// File: rtl/cam_sensor_emu.sv
// Camera sensor emulator: frames of programmable geometry and test pattern on a DVP bus.
// Bus outputs lag the internal state by one clk; the bus stays idle while PWDN is high.
module cam_sensor_emu #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PWDN,
  input  logic [1:0]              mode,
  input  logic [7:0]              pattern,
  cam_sensor_emu_if.master        dvp,
  output logic                    frame_done,
  output logic [15:0]             frame_cnt
);

  localparam int LINE_LEN = H_ACTIVE + H_BLANK;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [7:0]  inc_q, inc_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  pat_q, pat_d;
  logic        pclk_q, pclk_d;
  logic        href_q, href_d;
  logic        vsyn_q, vsyn_d;
  logic [7:0]  data_q, data_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [15:0] v_last;
  logic        active_px;
  logic [7:0]  pix;

  always_comb begin
    v_last = '0;
    case (state_q)
      VSYNC:   v_last = 16'(V_SYNC - 1);
      VBACK:   v_last = 16'(V_BACK - 1);
      ACTIVE:  v_last = 16'(V_ACTIVE - 1);
      VFRONT:  v_last = 16'(V_FRONT - 1);
      default: v_last = '0;
    endcase
  end

  assign active_px = (state_q == ACTIVE) && (h_cnt_q < 16'(H_ACTIVE));

  always_comb begin
    pix = inc_q;
    case (mode_q)
      2'b00:   pix = inc_q;
      2'b01:   pix = pat_q;
      2'b10:   pix = 8'(v_cnt_q);
      default: pix = 8'(h_cnt_q);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    inc_d        = inc_q;
    mode_d       = mode_q;
    pat_d        = pat_q;
    pclk_d       = pclk_q;
    href_d       = href_q;
    vsyn_d       = vsyn_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (PWDN) begin
      // Power-down aborts any frame at once; only the frame counter survives.
      state_d = IDLE;
      phase_d = 1'b0;
      h_cnt_d = '0;
      v_cnt_d = '0;
      inc_d   = '0;
      pclk_d  = 1'b0;
      href_d  = 1'b0;
      vsyn_d  = 1'b0;
      data_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = VSYNC;
      phase_d = 1'b0;
      h_cnt_d = '0;
      v_cnt_d = '0;
      inc_d   = '0;
      mode_d  = mode;
      pat_d   = pattern;
    end else begin
      phase_d = ~phase_q;
      pclk_d  = phase_q;
      if (!phase_q) begin
        // Pclk is about to fall: present the bus for the coming Pclk period.
        href_d = active_px;
        vsyn_d = (state_q == VSYNC);
        data_d = active_px ? pix : 8'd0;
        if (active_px) inc_d = inc_q + 8'd1;
      end else if (h_cnt_q == 16'(LINE_LEN - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q == v_last) begin
          v_cnt_d = '0;
          case (state_q)
            VSYNC:   state_d = VBACK;
            VBACK:   state_d = ACTIVE;
            ACTIVE:  state_d = VFRONT;
            default: begin
              state_d      = VSYNC;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              inc_d        = '0;
              mode_d       = mode;
              pat_d        = pattern;
            end
          endcase
        end else begin
          v_cnt_d = v_cnt_q + 16'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      inc_q        <= '0;
      mode_q       <= '0;
      pat_q        <= '0;
      pclk_q       <= 1'b0;
      href_q       <= 1'b0;
      vsyn_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      inc_q        <= inc_d;
      mode_q       <= mode_d;
      pat_q        <= pat_d;
      pclk_q       <= pclk_d;
      href_q       <= href_d;
      vsyn_q       <= vsyn_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dvp.Pclk   = pclk_q;
  assign dvp.Href   = href_q;
  assign dvp.Vsyn   = vsyn_q;
  assign dvp.data   = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Scoreboard bench for cam_sensor_emu with a 60-clk small-geometry frame.
module tb_cam_sensor_emu;
  localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 2, VF = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PWDN = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  pattern = 8'h00;
  logic        frame_done;
  logic [15:0] frame_cnt;

  cam_sensor_emu_if dvp ();

  cam_sensor_emu #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst(rst), .PWDN(PWDN), .mode(mode), .pattern(pattern),
    .dvp(dvp), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic       pclk_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT event", name);
  endtask

  // Monitor: a byte is captured on every Pclk rising edge with Href=1 and Vsyn=0.
  always @(negedge clk) begin
    if (dvp.Pclk && !pclk_prev && dvp.Href && !dvp.Vsyn) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", dvp.data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("pixel", 32'(dvp.data), 32'(exp_byte));
      end
    end
    pclk_prev = dvp.Pclk;
  end

  task automatic push_inc();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
  endtask

  task automatic restart(input logic [1:0] m, input logic [7:0] p);
    PWDN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mode    = m;
    pattern = p;
    PWDN    = 1'b0;
  endtask

  task automatic wait_frame_done(input string name, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (frame_done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) timeout_fail(name);
  endtask

  task automatic wait_href_rise(input string name);
    logic prev;
    logic seen;
    prev = dvp.Href;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dvp.Href && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = dvp.Href;
    end
    if (!seen) timeout_fail(name);
  endtask

  // Full frame from power-up: frame_done lands in the 61st clk after PWDN is sampled low.
  task automatic run_frame(input string name, input logic [1:0] m, input logic [7:0] p,
                           input logic [15:0] exp_cnt);
    int cyc;
    restart(m, p);
    wait_frame_done({name, "_timeout"}, cyc);
    check({name, "_latency"}, 32'(cyc), 32'd61);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    PWDN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int c;
    int fd_seen;

    repeat (2) @(negedge clk);
    check("reset_state", 32'({dvp.Pclk, dvp.Href, dvp.Vsyn, dvp.data, frame_done, frame_cnt}), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pwdn_idle", 32'({dvp.Pclk, dvp.Href, dvp.Vsyn, dvp.data, frame_done, frame_cnt}), 32'd0);
    end

    // Incrementing pattern, entry timing and frame length measured from Vsyn rise.
    push_inc();
    mode = 2'b00;
    PWDN = 1'b0;
    @(negedge clk);
    check("entry_edge_n", 32'({dvp.Vsyn, dvp.Pclk}), 32'd0);
    @(negedge clk);
    check("entry_vsyn", 32'({dvp.Vsyn, dvp.Pclk}), 32'b10);
    @(negedge clk);
    check("first_pclk_rise", 32'(dvp.Pclk), 32'd1);
    c = 0;
    for (int i = 3; i <= 300; i++) begin
      @(negedge clk);
      if (frame_done) begin
        c = i;
        break;
      end
    end
    if (c == 0) timeout_fail("inc_frame_done");
    check("frame_done_clk_after_vsyn", 32'(c), 32'd60);
    check("inc_frame_cnt", 32'(frame_cnt), 32'd1);
    check("inc_bytes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("frame_done_one_clk", 32'(frame_done), 32'd0);
    check("back_to_back_vsyn", 32'(dvp.Vsyn), 32'd1);
    PWDN = 1'b1;

    // Row and column index patterns.
    for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) exp_q.push_back(8'(r));
    run_frame("row", 2'b10, 8'h00, 16'd2);
    for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
    run_frame("col", 2'b11, 8'h00, 16'd3);

    // Mode change during ACTIVE only affects the following frame.
    for (int k = 0; k < 8; k++) exp_q.push_back(8'hA5);
    push_inc();
    restart(2'b01, 8'hA5);
    wait_href_rise("mid_href_timeout");
    mode = 2'b00;
    wait_frame_done("mid_fd1_timeout", c);
    check("mid_frame_cnt1", 32'(frame_cnt), 32'd4);
    check("mid_bytes_after_f1", 32'(exp_q.size()), 32'd8);
    wait_frame_done("mid_fd2_timeout", c);
    check("mid_frame_cnt2", 32'(frame_cnt), 32'd5);
    check("mid_bytes_after_f2", 32'(exp_q.size()), 32'd0);
    PWDN = 1'b1;

    // Abort in the first active line, then restart from a clean frame.
    restart(2'b00, 8'h00);
    wait_href_rise("abort_href_timeout");
    PWDN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_outputs", 32'({dvp.Href, dvp.Vsyn, dvp.Pclk, dvp.data}), 32'd0);
    fd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
    end
    check("abort_no_frame_done", 32'(fd_seen), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd5);
    push_inc();
    PWDN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_restart_vsyn", 32'(dvp.Vsyn), 32'd1);
    wait_frame_done("abort_fd_timeout", c);
    check("abort_restart_frame_cnt", 32'(frame_cnt), 32'd6);
    check("abort_restart_bytes_left", 32'(exp_q.size()), 32'd0);
    PWDN = 1'b1;

    // Asynchronous reset in the middle of an active line.
    restart(2'b10, 8'h00);
    wait_href_rise("arst_href_timeout");
    check("arst_href_before", 32'(dvp.Href), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_outputs", 32'({dvp.Pclk, dvp.Href, dvp.Vsyn, dvp.data, frame_done, frame_cnt}), 32'd0);
    @(negedge clk);
    PWDN = 1'b1;
    rst  = 1'b1;
    @(negedge clk);

    // Frame counter wrap from a preloaded 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("preload_frame_cnt", 32'(frame_cnt), 32'h0000FFFF);
    push_inc();
    run_frame("wrap", 2'b00, 8'h00, 16'd0);

    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
